// File: rtl/tw_ctrl_pkg.sv
// Shared constants for the HH:MM:SS time-setting controller: mode
// encodings, the FSM state type and the per-digit blink masks.
package tw_ctrl_pkg;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_HOUR   = 2'd1;
  localparam logic [1:0] MODE_MIN    = 2'd2;
  localparam logic [1:0] MODE_SEC    = 2'd3;

  // State values equal the externally visible set_mode encoding, so the
  // registered state can be driven straight onto set_mode.
  typedef enum logic [1:0] {
    ST_NORMAL = MODE_NORMAL,
    ST_HOUR   = MODE_HOUR,
    ST_MIN    = MODE_MIN,
    ST_SEC    = MODE_SEC
  } tw_state_e;

  // Digit masks: [5:4] hour tens/units, [3:2] minutes, [1:0] seconds.
  localparam logic [5:0] MASK_NONE = 6'b000000;
  localparam logic [5:0] MASK_HOUR = 6'b110000;
  localparam logic [5:0] MASK_MIN  = 6'b001100;
  localparam logic [5:0] MASK_SEC  = 6'b000011;
  localparam logic [5:0] MASK_ALL  = 6'b111111;

  // Which digits blink while a given field is being adjusted.
  function automatic logic [5:0] digit_mask(input tw_state_e st);
    logic [5:0] m;
    case (st)
      ST_HOUR: m = MASK_HOUR;
      ST_MIN:  m = MASK_MIN;
      ST_SEC:  m = MASK_SEC;
      default: m = MASK_NONE;
    endcase
    return m;
  endfunction

  // Mode key walks NORMAL -> HOUR -> MIN -> SEC -> NORMAL.
  function automatic tw_state_e next_mode(input tw_state_e st);
    tw_state_e n;
    case (st)
      ST_NORMAL: n = ST_HOUR;
      ST_HOUR:   n = ST_MIN;
      ST_MIN:    n = ST_SEC;
      default:   n = ST_NORMAL;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Free-running millisecond prescaler. Emits a registered one-cycle tick
// each time the cycle counter wraps from CNT_1MS-1 back to 0.
module ms_tick #(
  parameter int CNT_1MS = 50000
) (
  input  logic sysclk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (CNT_1MS > 1) ? $clog2(CNT_1MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_1MS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Count 0..CNT_1MS-1 forever; flag the wrap for exactly one cycle.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/tw_ctrl.sv
// Time-setting mode controller for the six-digit clock display.
// Runs the NORMAL/HOUR/MIN/SEC FSM, generates the shared blink waveform
// (0 = lit, 1 = dark), per-digit blink/valid enables and an exit pulse.
module tw_ctrl
  import tw_ctrl_pkg::*;
#(
  parameter int CNT_1MS    = 50000,
  parameter int BLINK_MS   = 500,
  parameter int TIMEOUT_MS = 10000
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_dn,
  input  logic       disp_en,
  output logic [1:0] set_mode,
  output logic       twinkle,
  output logic [5:0] twinkle_led,
  output logic [5:0] valid_led,
  output logic       set_exit
);

  localparam int BLINK_W = $clog2(BLINK_MS + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_MS + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_MS - 1);
  localparam logic [TMO_W-1:0]   TMO_MAX    = TMO_W'(TIMEOUT_MS);

  logic               w_tick;
  tw_state_e          r_state;
  tw_state_e          w_state_next;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_twinkle;
  logic [1:0]         r_set_mode;
  logic [5:0]         r_twinkle_led;
  logic [5:0]         r_valid_led;
  logic               r_set_exit;

  logic w_in_set;
  logic w_next_in_set;
  logic w_any_key;
  logic w_restart;
  logic w_expire;

  ms_tick #(
    .CNT_1MS(CNT_1MS)
  ) u_ms_tick (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_in_set      = (r_state != ST_NORMAL);
  assign w_next_in_set = (w_state_next != ST_NORMAL);
  assign w_any_key     = key_mode | key_up | key_dn;

  // In a set state any key restarts the blink phase; from NORMAL only the
  // mode key matters, and it restarts because it enters a set state.
  assign w_restart = w_in_set ? w_any_key : key_mode;

  // Expiry happens on the tick that would bring the inactivity count to
  // TIMEOUT_MS. A key in the same cycle always beats the timeout.
  assign w_expire = w_in_set && !w_any_key &&
                    ((w_tick && (r_tmo_cnt == TMO_LAST)) || (r_tmo_cnt >= TMO_MAX));

  // Next-state selection: a mode key advances, otherwise timeout drops to NORMAL.
  always_comb begin
    w_state_next = r_state;
    if (key_mode) begin
      w_state_next = next_mode(r_state);
    end else if (w_expire) begin
      w_state_next = ST_NORMAL;
    end
  end

  // FSM state plus its registered outputs, all decoded from the next state
  // so they change one cycle after the key.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_NORMAL;
      r_set_mode    <= MODE_NORMAL;
      r_twinkle_led <= MASK_NONE;
      r_set_exit    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_set_mode    <= w_state_next;
      r_twinkle_led <= digit_mask(w_state_next);
      r_set_exit    <= w_in_set && !w_next_in_set;
    end
  end

  // Blink generator: held lit in NORMAL and on every restart, otherwise
  // toggles once per BLINK_MS ticks.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_twinkle   <= 1'b0;
    end else if (!w_next_in_set || w_restart) begin
      r_blink_cnt <= '0;
      r_twinkle   <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_twinkle   <= ~r_twinkle;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Inactivity counter in ms; any key or leaving the set states clears it.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (!w_next_in_set || w_any_key) begin
      r_tmo_cnt <= '0;
    end else if (w_tick && (r_tmo_cnt < TMO_MAX)) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Digit valid follows the display enable with one cycle of latency.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_led <= MASK_NONE;
    end else begin
      r_valid_led <= disp_en ? MASK_ALL : MASK_NONE;
    end
  end

  assign set_mode    = r_set_mode;
  assign twinkle     = r_twinkle;
  assign twinkle_led = r_twinkle_led;
  assign valid_led   = r_valid_led;
  assign set_exit    = r_set_exit;

endmodule
